// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: INIT fills the S-box, KSA mixes in the key, and
// PRGA produces one keystream byte per accepted handshake for the XOR stage.
// The S-box is a 256x8 register array. Each cycle performs one KSA or one PRGA step.
//
// Output handshake: ksByte is valid while ksValid=1. The byte is consumed on a
// rising edge where ksValid=1 and ksReady=1. While ksValid=1 and ksReady=0,
// ksByte and all generator state hold. A new byte is produced whenever the
// output register is empty or is being drained in the same cycle. ksValid
// drops only on abort, on a fresh accepted initStart, or on reset.
module rc4_keystream_gen #(
  parameter int KEY_BYTES_MAX = 16
) (
  input  logic                       macCoreClk,
  input  logic                       macCoreClkSyncRst,
  input  logic                       initStart,
  input  logic [8*KEY_BYTES_MAX-1:0] keyIn,
  input  logic [4:0]                 keyLen,
  input  logic                       abort,
  input  logic                       ksReady,
  output logic                       ksValid,
  output logic [7:0]                 ksByte,
  output logic                       busy,
  output logic                       keyErr,
  output logic [1:0]                 dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_KSA  = 2'd2,
    ST_PRGA = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] s_box [256];
  logic [7:0] i_idx;
  logic [7:0] j_idx;

  // Captured key. The store is padded to 32 entries so the 5-bit key index
  // always addresses a real entry. Only the first keyLen entries are ever used.
  logic [255:0] key_pad;
  logic [7:0]   key_mem [32];
  logic [4:0]   key_len;
  logic [4:0]   k_idx;
  logic [4:0]   k_inc;

  logic       len_ok;
  logic       start_ok;
  logic       ksa_run;
  logic       prga_fire;

  logic [7:0] ksa_j;
  logic [7:0] p_i;
  logic [7:0] p_j;
  logic [7:0] p_si;
  logic [7:0] p_sj;
  logic [7:0] p_t;
  logic [7:0] p_out;

  assign key_pad  = 256'(keyIn);
  assign len_ok   = (keyLen != 5'd0) && (int'(keyLen) <= KEY_BYTES_MAX);
  // abort wins over a simultaneous initStart
  assign start_ok = initStart && len_ok && !abort;

  // A step is suppressed in any cycle that also restarts or aborts.
  assign ksa_run   = (state == ST_KSA) && !abort && !start_ok;
  assign prga_fire = (state == ST_PRGA) && (!ksValid || ksReady) && !abort && !start_ok;

  assign busy     = (state == ST_INIT) || (state == ST_KSA);
  assign dbgState = state;

  // KSA and PRGA step datapath, computed from the current S-box contents
  always_comb begin
    k_inc = k_idx + 5'd1;
    ksa_j = j_idx + s_box[i_idx] + key_mem[k_idx];
    p_i   = i_idx + 8'd1;
    p_si  = s_box[p_i];
    p_j   = j_idx + p_si;
    p_sj  = s_box[p_j];
    p_t   = p_si + p_sj;
    // Read S[t] as it will look after the swap.
    if (p_t == p_i) begin
      p_out = p_sj;
    end else if (p_t == p_j) begin
      p_out = p_si;
    end else begin
      p_out = s_box[p_t];
    end
  end

  // Next-state logic: abort first, then restart, then normal progression
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (start_ok) begin
      state_next = ST_INIT;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_INIT: state_next = ST_KSA;
        ST_KSA:  state_next = (i_idx == 8'd255) ? ST_PRGA : ST_KSA;
        ST_PRGA: state_next = ST_PRGA;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSyncRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Key and length capture on an accepted initStart
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSyncRst) begin
      key_len <= 5'd1;
    end else if (start_ok) begin
      key_len <= keyLen;
    end
  end

  // Key byte store, loaded alongside key_len
  always_ff @(posedge macCoreClk) begin
    if (start_ok) begin
      for (int b = 0; b < 32; b++) begin
        key_mem[b] <= key_pad[b*8 +: 8];
      end
    end
  end

  // Index registers i, j and the key index
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSyncRst || abort) begin
      i_idx <= 8'd0;
      j_idx <= 8'd0;
      k_idx <= 5'd0;
    end else if (start_ok || state == ST_INIT) begin
      i_idx <= 8'd0;
      j_idx <= 8'd0;
      k_idx <= 5'd0;
    end else if (ksa_run) begin
      if (i_idx == 8'd255) begin
        i_idx <= 8'd0;
        j_idx <= 8'd0;
      end else begin
        i_idx <= i_idx + 8'd1;
        j_idx <= ksa_j;
      end
      k_idx <= (k_inc == key_len) ? 5'd0 : k_inc;
    end else if (prga_fire) begin
      i_idx <= p_i;
      j_idx <= p_j;
    end
  end

  // S-box: identity fill in INIT, one swap per KSA or PRGA step.
  // There is no reset because the contents are meaningless until INIT runs.
  always_ff @(posedge macCoreClk) begin
    if (state == ST_INIT) begin
      for (int n = 0; n < 256; n++) begin
        s_box[n] <= 8'(n);
      end
    end else if (ksa_run) begin
      s_box[i_idx] <= s_box[ksa_j];
      s_box[ksa_j] <= s_box[i_idx];
    end else if (prga_fire) begin
      s_box[p_i] <= p_sj;
      s_box[p_j] <= p_si;
    end
  end

  // Output register, valid flag and key error pulse
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSyncRst) begin
      ksValid <= 1'b0;
      ksByte  <= 8'd0;
      keyErr  <= 1'b0;
    end else begin
      keyErr <= initStart && !len_ok;
      if (abort || start_ok) begin
        ksValid <= 1'b0;
      end else if (prga_fire) begin
        ksValid <= 1'b1;
        ksByte  <= p_out;
      end
    end
  end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Testbench for rc4_keystream_gen. Keystream bytes are compared against a
// plain array-based RC4 model. Timing, stalls, key errors, abort and reset
// are also checked.
module tb_rc4_keystream_gen;

  localparam int KB = 16;

  logic            macCoreClk = 1'b0;
  logic            macCoreClkSyncRst;
  logic            initStart;
  logic [8*KB-1:0] keyIn;
  logic [4:0]      keyLen;
  logic            abort;
  logic            ksReady;
  logic            ksValid;
  logic [7:0]      ksByte;
  logic            busy;
  logic            keyErr;
  logic [1:0]      dbgState;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_key [KB];
  int         cur_len;

  rc4_keystream_gen #(.KEY_BYTES_MAX(KB)) dut (
    .macCoreClk        (macCoreClk),
    .macCoreClkSyncRst (macCoreClkSyncRst),
    .initStart         (initStart),
    .keyIn             (keyIn),
    .keyLen            (keyLen),
    .abort             (abort),
    .ksReady           (ksReady),
    .ksValid           (ksValid),
    .ksByte            (ksByte),
    .busy              (busy),
    .keyErr            (keyErr),
    .dbgState          (dbgState)
  );

  // clock
  always #5 macCoreClk = ~macCoreClk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Textbook RC4: the queue receives the first n keystream bytes for cur_key/cur_len
  function automatic void build_ref(input int n);
    int s [256];
    int j;
    int i;
    int t;
    exp_q.delete();
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(cur_key[k % cur_len])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  // Load cur_key from packed bytes (byte 0 in bits 7:0). Unused bytes get random data.
  task automatic set_key(input int len, input logic [63:0] bytes);
    logic [63:0] v;
    v = bytes;
    cur_len = len;
    for (int b = 0; b < KB; b++) begin
      if (b < 8 && b < len) cur_key[b] = v[b*8 +: 8];
      else                  cur_key[b] = 8'($urandom);
    end
  endtask

  task automatic drive_key();
    for (int b = 0; b < KB; b++) keyIn[b*8 +: 8] = cur_key[b];
    keyLen = 5'(cur_len);
  endtask

  // Pulse initStart at a negedge, scramble the key inputs, and measure the
  // number of edges until the first valid byte appears.
  task automatic start_and_wait(input string tag);
    int lat;
    drive_key();
    initStart = 1'b1;
    ksReady   = 1'b0;
    @(negedge macCoreClk);
    initStart = 1'b0;
    keyIn     = {$urandom, $urandom, $urandom, $urandom};
    keyLen    = 5'($urandom_range(0, 31));
    check_eq({tag, "_busy_init"}, busy, 1);
    check_eq({tag, "_valid_drop"}, ksValid, 0);
    lat = 0;
    while (!ksValid && lat < 400) begin
      @(negedge macCoreClk);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 258);
  endtask

  // Consume n bytes with random ksReady. An optional 20-cycle hold starts
  // at byte hold_at. While stalled, the byte must stay put.
  task automatic run_stream(input string tag, input int n, input int stall_pct, input int hold_at);
    int         got;
    int         budget;
    int         hold_left;
    bit         hold_done;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] e;
    got = 0; budget = 0; hold_left = 0; hold_done = 0; stalled = 0; held = 8'd0;
    while (got < n && budget < 3000) begin
      if (stalled) begin
        check_eq({tag, "_stall_valid"}, ksValid, 1);
        check_eq({tag, "_stall_byte"}, ksByte, held);
      end
      if (hold_at >= 0 && got == hold_at && !hold_done) begin
        hold_left = 20;
        hold_done = 1;
      end
      if (hold_left > 0) begin
        ksReady = 1'b0;
        hold_left--;
      end else begin
        ksReady = ($urandom_range(0, 99) >= stall_pct);
      end
      stalled = 0;
      if (ksValid && ksReady) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_model_empty"}, got, n);
        end else begin
          e = exp_q.pop_front();
          check_eq({tag, "_byte"}, ksByte, e);
        end
        got++;
      end else if (ksValid) begin
        stalled = 1;
        held    = ksByte;
      end
      @(negedge macCoreClk);
      budget++;
    end
    if (got < n) check_eq({tag, "_timeout"}, got, n);
    ksReady = 1'b0;
  endtask

  task automatic pulse_bad_len(input string tag, input logic [4:0] len);
    keyIn     = {$urandom, $urandom, $urandom, $urandom};
    keyLen    = len;
    initStart = 1'b1;
    @(negedge macCoreClk);
    initStart = 1'b0;
    check_eq({tag, "_keyerr"}, keyErr, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, ksValid, 0);
    check_eq({tag, "_state"}, dbgState, 0);
    @(negedge macCoreClk);
    check_eq({tag, "_keyerr_pulse"}, keyErr, 0);
    check_eq({tag, "_state_hold"}, dbgState, 0);
  endtask

  // stimulus and final report
  initial begin
    int seen_valid;
    macCoreClkSyncRst = 1'b1;
    initStart = 1'b0;
    keyIn     = '0;
    keyLen    = 5'd0;
    abort     = 1'b0;
    ksReady   = 1'b0;
    repeat (3) @(negedge macCoreClk);
    check_eq("rst_valid", ksValid, 0);
    check_eq("rst_byte", ksByte, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_keyerr", keyErr, 0);
    check_eq("rst_state", dbgState, 0);
    macCoreClkSyncRst = 1'b0;
    @(negedge macCoreClk);

    // "Key", always ready
    set_key(3, 64'h0000_0000_0079_654B);
    build_ref(10);
    start_and_wait("key");
    check_eq("key_first_vec", ksByte, 8'hEB);
    run_stream("key", 10, 0, -1);

    // "Wiki" and "Secret", each restarting from PRGA
    set_key(4, 64'h0000_0000_696B_6957);
    build_ref(6);
    start_and_wait("wiki");
    check_eq("wiki_first_vec", ksByte, 8'h60);
    run_stream("wiki", 6, 0, -1);

    set_key(6, 64'h0000_7465_7263_6553);
    build_ref(8);
    start_and_wait("secret");
    check_eq("secret_first_vec", ksByte, 8'h04);
    run_stream("secret", 8, 0, -1);

    // random keys, random lengths, random stalls
    for (int r = 0; r < 3; r++) begin
      cur_len = $urandom_range(1, KB);
      for (int b = 0; b < KB; b++) cur_key[b] = 8'($urandom);
      build_ref(24);
      start_and_wait("rand");
      run_stream("rand", 24, 30, -1);
    end

    // "Key" with stalls, including a 20-cycle hold
    set_key(3, 64'h0000_0000_0079_654B);
    build_ref(10);
    start_and_wait("stall");
    run_stream("stall", 10, 40, 3);

    // illegal key lengths from IDLE
    abort = 1'b1;
    @(negedge macCoreClk);
    abort = 1'b0;
    check_eq("abort_idle_state", dbgState, 0);
    check_eq("abort_idle_valid", ksValid, 0);
    pulse_bad_len("len0", 5'd0);
    pulse_bad_len("len17", 5'd17);

    // abort at KSA step 100, then restart with "Wiki"
    set_key(4, 64'h0000_0000_696B_6957);
    drive_key();
    initStart = 1'b1;
    @(negedge macCoreClk);
    initStart = 1'b0;
    repeat (101) @(negedge macCoreClk);
    check_eq("ksa_state", dbgState, 2);
    check_eq("ksa_busy", busy, 1);
    abort = 1'b1;
    @(negedge macCoreClk);
    abort = 1'b0;
    check_eq("abort_state", dbgState, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", ksValid, 0);
    seen_valid = 0;
    ksReady = 1'b1;
    repeat (300) begin
      @(negedge macCoreClk);
      if (ksValid) seen_valid++;
    end
    ksReady = 1'b0;
    check_eq("abort_no_valid", seen_valid, 0);
    build_ref(6);
    start_and_wait("wiki2");
    check_eq("wiki2_first_vec", ksByte, 8'h60);
    run_stream("wiki2", 6, 20, -1);

    // reset mid-PRGA after 3 bytes, then re-init "Key"
    set_key(3, 64'h0000_0000_0079_654B);
    build_ref(10);
    start_and_wait("pre_rst");
    run_stream("pre_rst", 3, 0, -1);
    macCoreClkSyncRst = 1'b1;
    @(negedge macCoreClk);
    macCoreClkSyncRst = 1'b0;
    check_eq("mid_rst_valid", ksValid, 0);
    check_eq("mid_rst_byte", ksByte, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_keyerr", keyErr, 0);
    check_eq("mid_rst_state", dbgState, 0);
    build_ref(10);
    start_and_wait("post_rst");
    check_eq("post_rst_first_vec", ksByte, 8'hEB);
    run_stream("post_rst", 10, 25, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
